// File: rtl/temp_poll_monitor_if.sv
`timescale 1ns/1ps
// Handshake between the poll monitor and the DS18B20 controller:
// the monitor pulses start, the controller answers with readState and a temperature code.
interface temp_poll_monitor_if;
  logic       start;
  logic       readState;
  logic [8:0] temperature;

  modport master (output start, input readState, input temperature);
  modport slave  (input start, output readState, output temperature);
endinterface

// File: rtl/temp_poll_monitor.sv
`timescale 1ns/1ps
// Periodically triggers the DS18B20 controller, screens each completed read, keeps a
// moving average of accepted codes and raises a hysteretic over-temperature flag.
module temp_poll_monitor #(
  parameter int unsigned POLL_PERIOD = 10_000_000,
  parameter int unsigned TIMEOUT     = 2_000_000,
  parameter int unsigned AVG_LOG2    = 2,
  parameter logic [8:0]  HI_THRESH   = 9'd60,
  parameter logic [8:0]  LO_THRESH   = 9'd55
) (
  input  logic                CLK_10MHZ,
  input  logic                RST_N,
  input  logic                enable_i,
  temp_poll_monitor_if.master ctrl,
  output logic [8:0]          temp_last_o,
  output logic [8:0]          temp_avg_o,
  output logic                sample_valid_o,
  output logic                over_temp_o,
  output logic                sensor_fault_o,
  output logic [7:0]          sample_count_o
);

  localparam int unsigned DEPTH = 1 << AVG_LOG2;
  localparam int unsigned PW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned SW    = 9 + AVG_LOG2;
  localparam int unsigned PCW   = $clog2(POLL_PERIOD);
  localparam int unsigned TCW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [PCW-1:0] PERIOD_LAST = PCW'(POLL_PERIOD - 1);
  localparam logic [TCW-1:0] TO_LAST     = TCW'(TIMEOUT - 1);
  localparam logic [PW-1:0]  WP_LAST     = PW'(DEPTH - 1);
  localparam logic [8:0]     CODE_ERR    = 9'h1FF;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_WAIT_PERIOD = 3'd1,
    ST_PULSE       = 3'd2,
    ST_WAIT_RISE   = 3'd3,
    ST_WAIT_FALL   = 3'd4,
    ST_CAPTURE     = 3'd5
  } state_e;

  state_e         state_q, state_d;
  logic [PCW-1:0] period_cnt_q, period_cnt_d;
  logic [TCW-1:0] to_cnt_q, to_cnt_d;
  logic           start_q, start_d;

  logic           rs_meta_q, rs_sync_q, rs_prev_q;
  logic [8:0]     temp_meta_q, temp_sync_q;
  logic           rise_s, fall_s, capture_s, timeout_s;

  logic           first_flag_q, first_flag_d;
  logic           buf_init_q, buf_init_d;
  logic [8:0]     buf_q [DEPTH];
  logic           buf_fill_s, buf_wr_s;
  logic [PW-1:0]  wp_q, wp_d;
  logic [SW-1:0]  sum_q, sum_d;

  logic [8:0]     temp_last_q, temp_last_d;
  logic [8:0]     temp_avg_q, temp_avg_d;
  logic           sample_valid_q, sample_valid_d;
  logic           over_temp_q, over_temp_d;
  logic           sensor_fault_q, sensor_fault_d;
  logic [7:0]     sample_count_q, sample_count_d;

  assign rise_s = rs_sync_q & ~rs_prev_q;
  assign fall_s = ~rs_sync_q & rs_prev_q;

  // Two-flop synchronisers for the controller outputs plus an edge-detect history flop
  always_ff @(posedge CLK_10MHZ or negedge RST_N) begin
    if (!RST_N) begin
      rs_meta_q   <= 1'b0;
      rs_sync_q   <= 1'b0;
      rs_prev_q   <= 1'b0;
      temp_meta_q <= 9'd0;
      temp_sync_q <= 9'd0;
    end else begin
      rs_meta_q   <= ctrl.readState;
      rs_sync_q   <= rs_meta_q;
      rs_prev_q   <= rs_sync_q;
      temp_meta_q <= ctrl.temperature;
      temp_sync_q <= temp_meta_q;
    end
  end

  // Poll sequencer state and its period / timeout counters
  always_ff @(posedge CLK_10MHZ or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= ST_IDLE;
      period_cnt_q <= {PCW{1'b0}};
      to_cnt_q     <= {TCW{1'b0}};
      start_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      to_cnt_q     <= to_cnt_d;
      start_q      <= start_d;
    end
  end

  // Next-state logic; dropping enable abandons whatever poll is in flight
  always_comb begin
    state_d      = state_q;
    period_cnt_d = period_cnt_q;
    to_cnt_d     = to_cnt_q;
    capture_s    = 1'b0;
    timeout_s    = 1'b0;
    if (!enable_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d      = ST_WAIT_PERIOD;
          period_cnt_d = {PCW{1'b0}};
        end
        ST_WAIT_PERIOD: begin
          if (period_cnt_q == PERIOD_LAST) begin
            state_d = ST_PULSE;
          end else begin
            period_cnt_d = period_cnt_q + PCW'(1'b1);
          end
        end
        ST_PULSE: begin
          state_d  = ST_WAIT_RISE;
          to_cnt_d = {TCW{1'b0}};
        end
        ST_WAIT_RISE: begin
          if (rise_s) begin
            state_d  = ST_WAIT_FALL;
            to_cnt_d = {TCW{1'b0}};
          end else if (to_cnt_q == TO_LAST) begin
            timeout_s    = 1'b1;
            state_d      = ST_WAIT_PERIOD;
            period_cnt_d = {PCW{1'b0}};
          end else begin
            to_cnt_d = to_cnt_q + TCW'(1'b1);
          end
        end
        ST_WAIT_FALL: begin
          if (fall_s) begin
            state_d = ST_CAPTURE;
          end else if (to_cnt_q == TO_LAST) begin
            timeout_s    = 1'b1;
            state_d      = ST_WAIT_PERIOD;
            period_cnt_d = {PCW{1'b0}};
          end else begin
            to_cnt_d = to_cnt_q + TCW'(1'b1);
          end
        end
        ST_CAPTURE: begin
          capture_s    = 1'b1;
          state_d      = ST_WAIT_PERIOD;
          period_cnt_d = {PCW{1'b0}};
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    start_d = (state_d == ST_PULSE);
  end

  // Sample screening and running-sum update; the very first read after reset is stale
  always_comb begin
    first_flag_d   = first_flag_q;
    buf_init_d     = buf_init_q;
    buf_fill_s     = 1'b0;
    buf_wr_s       = 1'b0;
    wp_d           = wp_q;
    sum_d          = sum_q;
    temp_last_d    = temp_last_q;
    temp_avg_d     = temp_avg_q;
    sample_valid_d = 1'b0;
    sensor_fault_d = sensor_fault_q;
    sample_count_d = sample_count_q;
    if (timeout_s) begin
      sensor_fault_d = 1'b1;
    end else if (capture_s) begin
      if (temp_sync_q == CODE_ERR) begin
        sensor_fault_d = 1'b1;
      end else if (first_flag_q) begin
        first_flag_d = 1'b0;
      end else begin
        temp_last_d    = temp_sync_q;
        sensor_fault_d = 1'b0;
        sample_valid_d = 1'b1;
        sample_count_d = (sample_count_q == 8'hFF) ? sample_count_q : sample_count_q + 8'd1;
        if (!buf_init_q) begin
          buf_fill_s = 1'b1;
          buf_init_d = 1'b1;
          sum_d      = SW'(temp_sync_q) << AVG_LOG2;
        end else begin
          buf_wr_s = 1'b1;
          sum_d    = sum_q - SW'(buf_q[wp_q]) + SW'(temp_sync_q);
        end
        temp_avg_d = 9'(sum_d >> AVG_LOG2);
        wp_d       = (wp_q == WP_LAST) ? {PW{1'b0}} : wp_q + PW'(1'b1);
      end
    end else begin
      sample_valid_d = 1'b0;
    end
  end

  // Hysteresis follows the registered average, so it lags it by one cycle
  always_comb begin
    if (temp_avg_q >= HI_THRESH) begin
      over_temp_d = 1'b1;
    end else if (temp_avg_q <= LO_THRESH) begin
      over_temp_d = 1'b0;
    end else begin
      over_temp_d = over_temp_q;
    end
  end

  // Result registers
  always_ff @(posedge CLK_10MHZ or negedge RST_N) begin
    if (!RST_N) begin
      first_flag_q   <= 1'b1;
      buf_init_q     <= 1'b0;
      wp_q           <= {PW{1'b0}};
      sum_q          <= {SW{1'b0}};
      temp_last_q    <= 9'd0;
      temp_avg_q     <= 9'd0;
      sample_valid_q <= 1'b0;
      over_temp_q    <= 1'b0;
      sensor_fault_q <= 1'b0;
      sample_count_q <= 8'd0;
    end else begin
      first_flag_q   <= first_flag_d;
      buf_init_q     <= buf_init_d;
      wp_q           <= wp_d;
      sum_q          <= sum_d;
      temp_last_q    <= temp_last_d;
      temp_avg_q     <= temp_avg_d;
      sample_valid_q <= sample_valid_d;
      over_temp_q    <= over_temp_d;
      sensor_fault_q <= sensor_fault_d;
      sample_count_q <= sample_count_d;
    end
  end

  // Averaging window; the first accepted code fills every slot
  always_ff @(posedge CLK_10MHZ or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        buf_q[i] <= 9'd0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (buf_fill_s || (buf_wr_s && (wp_q == PW'(i)))) begin
          buf_q[i] <= temp_sync_q;
        end else begin
          buf_q[i] <= buf_q[i];
        end
      end
    end
  end

  assign ctrl.start     = start_q;
  assign temp_last_o    = temp_last_q;
  assign temp_avg_o     = temp_avg_q;
  assign sample_valid_o = sample_valid_q;
  assign over_temp_o    = over_temp_q;
  assign sensor_fault_o = sensor_fault_q;
  assign sample_count_o = sample_count_q;

endmodule
